// File: rtl/ccu_frame_pkg.sv
// Shared types and sizing helpers for the count frame sequencer.
package ccu_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    CHK
  } state_e;

  localparam logic [7:0] DEFAULT_HEADER = 8'd47;

  function automatic int nbytes(input int w);
    return (w + 7) / 8;
  endfunction

  // Never returns less than 1, so a single-entry index still has a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/frame_byte_select.sv
// Picks one big-endian byte of one channel out of the count snapshot.
module frame_byte_select
  import ccu_frame_pkg::*;
#(
  parameter int N_CH  = 9,
  parameter int CNT_W = 16,
  parameter int CH_W  = clog2(N_CH),
  parameter int BY_W  = clog2(nbytes(CNT_W))
) (
  input  logic [N_CH*CNT_W-1:0] snap,
  input  logic [CH_W-1:0]       ch,
  input  logic [BY_W-1:0]       byte_idx,
  output logic [7:0]            data
);

  localparam int NB = nbytes(CNT_W);

  logic [NB*8-1:0] word;

  // Byte index 0 is the most significant byte of the zero-padded count.
  always_comb begin
    word = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch == CH_W'(k)) word[CNT_W-1:0] = snap[k*CNT_W +: CNT_W];
    end
    data = 8'h00;
    for (int b = 0; b < NB; b++) begin
      if (byte_idx == BY_W'(b)) data = word[(NB-1-b)*8 +: 8];
    end
  end

endmodule

// File: rtl/count_frame_sequencer.sv
// Snapshots the counter bank and streams header, big-endian counts and an
// optional checksum to a valid/ready byte sink.
module count_frame_sequencer
  import ccu_frame_pkg::*;
#(
  parameter int         N_CH        = 9,
  parameter int         CNT_W       = 16,
  parameter logic [7:0] HEADER      = DEFAULT_HEADER,
  parameter int         CHECKSUM_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_CH*CNT_W-1:0] counts_flat,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int NB   = nbytes(CNT_W);
  localparam int CH_W = clog2(N_CH);
  localparam int BY_W = clog2(NB);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
  localparam logic [BY_W-1:0] LAST_BY = BY_W'(NB - 1);

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d, nxt_ch;
  logic [BY_W-1:0]         byte_q, byte_d, nxt_byte;
  logic [N_CH*CNT_W-1:0]   snap_q, snap_d;
  logic [7:0]              csum_q, csum_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    busy_q, busy_d;
  logic                    frame_done_q, frame_done_d;
  logic                    last_byte;
  logic                    hs;
  logic [7:0]              sel_data;

  // The selector looks ahead at the byte that follows the one on the wire.
  always_comb begin
    last_byte = (ch_q == LAST_CH) && (byte_q == LAST_BY);
    nxt_ch    = ch_q;
    nxt_byte  = byte_q + BY_W'(1);
    if (state_q == HDR) begin
      nxt_ch   = '0;
      nxt_byte = '0;
    end else if (byte_q == LAST_BY) begin
      nxt_ch   = ch_q + CH_W'(1);
      nxt_byte = '0;
    end
  end

  frame_byte_select #(
    .N_CH (N_CH),
    .CNT_W(CNT_W),
    .CH_W (CH_W),
    .BY_W (BY_W)
  ) u_sel (
    .snap    (snap_q),
    .ch      (nxt_ch),
    .byte_idx(nxt_byte),
    .data    (sel_data)
  );

  assign hs = tx_valid_q && tx_ready;

  // NOTE: every _d gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    byte_d       = byte_q;
    snap_d       = snap_q;
    csum_d       = csum_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          snap_d     = counts_flat;
          csum_d     = HEADER;
          tx_data_d  = HEADER;
          tx_valid_d = 1'b1;
          state_d    = HDR;
        end
      end
      HDR: begin
        if (hs) begin
          tx_data_d = sel_data;
          ch_d      = nxt_ch;
          byte_d    = nxt_byte;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (hs) begin
          csum_d = csum_q + tx_data_q;
          if (!last_byte) begin
            tx_data_d = sel_data;
            ch_d      = nxt_ch;
            byte_d    = nxt_byte;
          end else if (CHECKSUM_EN != 0) begin
            tx_data_d = csum_q + tx_data_q;
            state_d   = CHK;
          end else begin
            tx_valid_d   = 1'b0;
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      CHK: begin
        if (hs) begin
          tx_valid_d   = 1'b0;
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      byte_q       <= '0;
      snap_q       <= '0;
      csum_q       <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      byte_q       <= byte_d;
      snap_q       <= snap_d;
      csum_q       <= csum_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
